// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control FSM and the HI/LO multiply/divide unit.
// The control FSM is the master; the unit is the slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    output hi_we, lo_we, wdata,
    input  hi, lo, busy, done,
    input  div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    input  hi_we, lo_we, wdata,
    output hi, lo, busy, done,
    output div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle HI/LO unit: MULT/MULTU by shift-add, DIV/DIVU by restoring division.
// Works on unsigned magnitudes, then fixes result signs in one extra cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic clk,
  input  logic reset,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             is_div;
  logic             neg_q;
  logic             rneg_q;

  logic             s_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_top;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    s_signed = ~bus.op[0];
    a_neg    = s_signed & bus.a[WIDTH-1];
    b_neg    = s_signed & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, mag_a} : '0);
    // shifted partial remainder needs one extra bit
    rem_top  = acc[2*WIDTH-1:WIDTH-1];
    rem_ge   = rem_top >= {1'b0, mag_b};
    rem_sub  = rem_top[WIDTH-1:0] - mag_b;
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0]
                     : acc[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc[2*WIDTH-1:WIDTH]
                      : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[1];
            mag_a  <= a_mag;
            mag_b  <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dz_q   <= 1'b0;
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}},
                       bus.op[1] ? a_mag : b_mag};
            if (bus.op[1] && bus.b == '0) begin
              hi_q   <= bus.a;
              lo_q   <= '1;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= S_RUN;
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        S_RUN: begin
          unique case (1'b1)
            is_div: begin
              acc <= rem_ge
                ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                : {rem_top[WIDTH-1:0],
                   acc[WIDTH-2:0], 1'b0};
            end
            !is_div: begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
          endcase
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          {hi_q, lo_q} <= is_div
            ? {rem_fix, quo_fix} : prod_fix;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at start,
// popped and compared on done.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          dcyc;
  } exp_t;

  exp_t sb[$];

  mult_div_unit_if #(.WIDTH(32)) bus();

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa;
    longint sb2;
    int     qa;
    int     qb;
    int     q;
    int     r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    qa  = $signed(a);
    qb  = $signed(b);
    res = '0;
    case (op)
      2'd0: res = 64'(sa * sb2);
      2'd1: res = {32'b0, a} * {32'b0, b};
      2'd2: begin
        q   = qa / qb;
        r   = qa % qb;
        res = {32'(r), 32'(q)};
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction

  // Issue one operation and follow it to done.
  // glitch: cycle at which a stray start/hi_we is pulsed (-1 = none).
  task automatic run_op(
    input string       name,
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] eh,
    input logic [31:0] el,
    input logic        edz,
    input int          edc,
    input int          glitch,
    input logic        we_start
  );
    exp_t e;
    exp_t got_e;
    logic got;
    logic bad_busy;
    int   bad_cyc;
    logic exp_busy;
    e.hi = eh;
    e.lo = el;
    e.dz = edz;
    e.dcyc = edc;
    sb.push_back(e);
    next_cycle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (we_start) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    next_cycle();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    got = 1'b0;
    bad_busy = 1'b0;
    bad_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      exp_busy = (edc == 34) && (c <= 33);
      if (bus.busy !== exp_busy && !bad_busy) begin
        bad_busy = 1'b1;
        bad_cyc = c;
      end
      if (bus.done === 1'b1) begin
        got = 1'b1;
        got_e = sb.pop_front();
        vectors++;
        if (c !== got_e.dcyc) begin
          miscompares++;
          $display("FAIL %s done_cycle: got %0d want %0d",
                   name, c, got_e.dcyc);
        end
        vectors++;
        if (bus.hi !== got_e.hi) begin
          miscompares++;
          $display("FAIL %s hi: got %h want %h",
                   name, bus.hi, got_e.hi);
        end
        vectors++;
        if (bus.lo !== got_e.lo) begin
          miscompares++;
          $display("FAIL %s lo: got %h want %h",
                   name, bus.lo, got_e.lo);
        end
        vectors++;
        if (bus.div_by_zero !== got_e.dz) begin
          miscompares++;
          $display("FAIL %s div_by_zero: got %b want %b",
                   name, bus.div_by_zero, got_e.dz);
        end
        break;
      end
      if (c == glitch) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h5555_5555;
      end else begin
        idle_inputs();
      end
      next_cycle();
    end
    idle_inputs();
    vectors++;
    if (bad_busy) begin
      miscompares++;
      $display("FAIL %s busy: wrong at cycle %0d want busy 1..33",
               name, bad_cyc);
    end
    if (!got) begin
      vectors++;
      miscompares++;
      void'(sb.pop_front());
      $display("FAIL %s timeout: got no done want done by 60", name);
    end else begin
      cur_hi = eh;
      cur_lo = el;
      next_cycle();
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after_done: got done=%b busy=%b want 0 0",
                 name, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero}
        !== 67'b0) begin
      miscompares++;
      $display("FAIL reset_state: got hi=%h lo=%h b=%b d=%b z=%b want 0",
               bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero);
    end
    repeat (2) next_cycle();
    reset = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
  endtask

  task automatic test_mult();
    run_op("mult_7_m3", 2'd0, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, -1, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, -1, 1'b0);
    run_op("mult_m1_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0, 32'h1, 1'b0, 34, -1, 1'b0);
  endtask

  task automatic test_div();
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, -1, 1'b0);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 34, -1, 1'b0);
    run_op("div_overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, 1'b0, 34, -1, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op("div_by_zero", 2'd2, 32'h1234, 32'h0,
           32'h1234, 32'hFFFF_FFFF, 1'b1, 1, -1, 1'b0);
    vectors++;
    if (bus.div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_sticky: got %b want 1", bus.div_by_zero);
    end
    run_op("mult_clears_dz", 2'd0, 32'd2, 32'd3,
           32'd0, 32'd6, 1'b0, 34, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_op("start_while_busy", 2'd0, 32'd1000, 32'd1000,
           32'd0, 32'd1000000, 1'b0, 34, 10, 1'b0);
  endtask

  task automatic test_mt_write();
    next_cycle();
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAA;
    next_cycle();
    idle_inputs();
    vectors++;
    if (bus.hi !== 32'hAA || bus.lo !== cur_lo) begin
      miscompares++;
      $display("FAIL mthi: got hi=%h lo=%h want hi=000000aa lo=%h",
               bus.hi, bus.lo, cur_lo);
    end
    bus.lo_we = 1'b1;
    bus.wdata = 32'h55;
    next_cycle();
    idle_inputs();
    vectors++;
    if (bus.hi !== 32'hAA || bus.lo !== 32'h55) begin
      miscompares++;
      $display("FAIL mtlo: got hi=%h lo=%h want 000000aa 00000055",
               bus.hi, bus.lo);
    end
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    next_cycle();
    idle_inputs();
    vectors++;
    if (bus.hi !== 32'h0BAD_F00D || bus.lo !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h want 0badf00d both",
               bus.hi, bus.lo);
    end
    cur_hi = 32'h0BAD_F00D;
    cur_lo = 32'h0BAD_F00D;
  endtask

  task automatic test_we_with_start();
    run_op("hi_we_with_start", 2'd1, 32'h0001_0000, 32'h0003_0000,
           32'h3, 32'h0, 1'b0, 34, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    next_cycle();
    bus.start = 1'b1;
    bus.op    = 2'd2;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    next_cycle();
    idle_inputs();
    repeat (19) next_cycle();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b want 0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    repeat (2) next_cycle();
    reset = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_abandon: got done/busy=%b hi=%h lo=%h want 0",
               saw_done, bus.hi, bus.lo);
    end
    run_op("divu_after_reset", 2'd3, 32'd9, 32'd3,
           32'd0, 32'd3, 1'b0, 34, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 4);
      a  = $urandom;
      b  = $urandom;
      if (op[1] && b == 32'h0) b = 32'd5;
      if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        b = 32'd7;
      r = model(op, a, b);
      run_op("random_op", op, a, b, r[63:32], r[31:0],
             1'b0, 34, -1, 1'b0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_mt_write();
    test_we_with_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits beside the ALU in the multicycle datapath and consumes the A/B register outputs.
- Holds results in internal HI/LO registers, which feed the write-back mux for MFHI/MFLO.
- Started by a one-cycle pulse from the control FSM, which stalls on busy and advances on done.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start.
- a  input  WIDTH  operand rs (multiplicand or dividend).
- b  input  WIDTH  operand rt (multiplier or divisor).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register (product high word or remainder).
- lo  output  WIDTH  LO register (product low word or quotient).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- div_by_zero  output  1  set by DIV/DIVU with b=0; cleared by the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi, lo, busy, done and div_by_zero all 0.
  - Any in-flight operation is abandoned; no partial result reaches HI/LO.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1 (cycle 0):
  - Latch op, a and b.
  - For signed ops, latch magnitudes |a| and |b|, plus result-sign flags: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear div_by_zero and the iteration counter.
  - Go to RUN, except divide with b=0, which goes to DONE.
- RUN:
  - One shift-add (multiply) or restoring-subtract (divide) step per cycle on the unsigned magnitudes.
  - Internal accumulator is 2*WIDTH wide.
  - Counter counts 0..ITER-1; leave for FIX after the step at count ITER-1 (cycles 1..32).
- FIX (cycle 33):
  - Apply two's-complement negation per the sign flags.
  - Write hi/lo at the end of the cycle.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
- DONE (cycle 34): done=1 for exactly one cycle, then IDLE.
- Timing: busy=1 in RUN and FIX only (cycles 1..33). hi/lo are stable from cycle 34 until the next write.
- Divide by zero:
  - IDLE -> DONE directly; done pulses in cycle 1.
  - hi=a, lo=0xFFFFFFFF, div_by_zero=1.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (modular negation); no flag.
- start while busy=1, or in DONE: ignored; the in-flight operation is unaffected.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; write takes effect at the clock edge.
  - If start=1 in the same cycle, start has priority and the writes are dropped.
  - Ignored in RUN, FIX and DONE.
- hi_we and lo_we together: both registers take wdata.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Signed multiply: MULT a=7, b=0xFFFFFFFD (-3) -> busy cycles 1..33, done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Unsigned divide: DIVU a=100, b=7 -> lo=14, hi=2.
- Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIV a=0x1234, b=0 -> done in cycle 1, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. Next MULT clears the flag.
- Control corner cases:
  - start pulse at cycle 10 of a MULT -> ignored; result unchanged.
  - hi_we=1, wdata=0xAA in IDLE -> hi=0xAA.
  - hi_we together with start -> hi holds the multiply result.
  - Assert reset at cycle 20 of a DIV -> hi=lo=0, busy=0, no done pulse. A fresh DIVU 9/3 afterwards -> lo=3, hi=0.
